// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, two writeback ports,
// issue and flush requests, and the scoreboard outputs.
// master = decode/writeback side driving requests; slave = register file.
interface regfile_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;

    logic                wr0_en;
    logic [AW-1:0]       wr0_addr;
    logic [XLEN-1:0]     wr0_data;

    logic                wr1_en;
    logic [AW-1:0]       wr1_addr;
    logic [XLEN-1:0]     wr1_data;

    logic                issue_en;
    logic [AW-1:0]       issue_addr;
    logic                flush;

    logic [NREGS-1:0]    busy_vec;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data,
               issue_en, issue_addr, flush,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data,
               wr1_en, wr1_addr, wr1_data,
               issue_en, issue_addr, flush,
        output rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: NREGS x XLEN integer register file with NRD
// combinational read ports, two synchronous write ports (wr0 = ALU,
// wr1 = load; wr1 wins on an address collision), hardwired-zero register 0,
// and a per-register busy scoreboard (set at issue, cleared at writeback,
// cleared wholesale by flush).
// Optional feature macro: REGFILE_BYPASS_EN -- forwards same-cycle write
// data to the read ports and reports them not busy.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_scoreboard_if.slave  bus
);
    localparam int AW = $clog2(NREGS);

    // Register 0 is not stored; entries 1..NREGS-1 only.
    logic [XLEN-1:0]  r_regs [1:NREGS-1];
    logic [NREGS-1:1] r_busy;
    logic [NREGS-1:1] w_busy_nxt;

    // Full-width views with entry 0 tied to zero, so reads index directly.
    logic [XLEN-1:0]  w_regs [NREGS];
    logic [NREGS-1:0] w_busy_all;

    // Register storage: load port overrides ALU port on the same address.
    // NOTE: the array is reset because a reset register file must read 0;
    // this rules out a RAM macro but matches the required reset behaviour.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 1; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NREGS; k++) begin
                if (bus.wr1_en && bus.wr1_addr == AW'(k)) begin
                    r_regs[k] <= bus.wr1_data;
                end else if (bus.wr0_en && bus.wr0_addr == AW'(k)) begin
                    r_regs[k] <= bus.wr0_data;
                end
            end
        end
    end

    // Scoreboard next state: flush, then issue, then writeback clear.
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch can be inferred on untaken branches.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int k = 1; k < NREGS; k++) begin
            if (bus.flush) begin
                w_busy_nxt[k] = 1'b0;
            end else if (bus.issue_en && bus.issue_addr == AW'(k)) begin
                // The writeback belongs to an older instruction; the new
                // producer keeps the register busy.
                w_busy_nxt[k] = 1'b1;
            end else if ((bus.wr0_en && bus.wr0_addr == AW'(k)) ||
                         (bus.wr1_en && bus.wr1_addr == AW'(k))) begin
                w_busy_nxt[k] = 1'b0;
            end
        end
    end

    // Scoreboard state register.
    // NOTE: sequential state uses non-blocking '<=' so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Zero-extended views of storage and scoreboard.
    always_comb begin
        w_regs[0] = '0;
        for (int k = 1; k < NREGS; k++) begin
            w_regs[k] = r_regs[k];
        end
        w_busy_all = {r_busy, 1'b0};
    end

    assign bus.busy_vec = w_busy_all;

    // Read ports: stored value and busy bit, optionally overridden by a
    // same-cycle write (wr1 before wr0, mirroring the write-conflict rule).
    always_comb begin
        logic [AW-1:0]   w_a;
        logic [XLEN-1:0] w_d;
        logic            w_b;
        w_a         = '0;
        w_d         = '0;
        w_b         = 1'b0;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            w_a = bus.rd_addr[i*AW +: AW];
            w_d = w_regs[w_a];
            w_b = w_busy_all[w_a];
`ifdef REGFILE_BYPASS_EN
            // Writes are discarded during reset, so they are not forwarded.
            if (reset_n && w_a != '0) begin
                if (bus.wr1_en && bus.wr1_addr == w_a) begin
                    w_d = bus.wr1_data;
                    w_b = 1'b0;
                end else if (bus.wr0_en && bus.wr0_addr == w_a) begin
                    w_d = bus.wr0_data;
                    w_b = 1'b0;
                end
            end
`endif
            bus.rd_data[i*XLEN +: XLEN] = w_d;
            bus.rd_busy[i]              = w_b;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard. A driver applies one stimulus
// per cycle, predicts the outputs from a plain array model of the register
// file and scoreboard, and queues the prediction; a monitor samples the DUT
// late in the same cycle and compares against the queue head.
module tb_regfile_scoreboard;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 4;
    localparam int AW    = $clog2(NREGS);
    localparam int CW    = NRD * XLEN;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    regfile_scoreboard_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst_n;
        logic [AW-1:0]   ra [NRD];
        logic            wr0_en;
        logic [AW-1:0]   wr0_addr;
        logic [XLEN-1:0] wr0_data;
        logic            wr1_en;
        logic [AW-1:0]   wr1_addr;
        logic [XLEN-1:0] wr1_data;
        logic            issue_en;
        logic [AW-1:0]   issue_addr;
        logic            flush;
        string           tag;
    } stim_t;

    typedef struct {
        logic [CW-1:0]    rd_data;
        logic [NRD-1:0]   rd_busy;
        logic [NREGS-1:0] busy_vec;
        string            tag;
    } exp_t;

    exp_t exp_q [$];

    // Reference model: architectural register values and busy flags.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];

    int n_vectors     = 0;
    int n_miscompares = 0;
    bit stim_done     = 1'b0;

    task automatic check(input string name, input logic [CW-1:0] act,
                         input logic [CW-1:0] expv);
        if (act !== expv) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic stim_t idle(input string tag);
        stim_t s;
        s.rst_n = 1'b1;
        for (int i = 0; i < NRD; i++) s.ra[i] = '0;
        s.wr0_en     = 1'b0;
        s.wr0_addr   = '0;
        s.wr0_data   = '0;
        s.wr1_en     = 1'b0;
        s.wr1_addr   = '0;
        s.wr1_data   = '0;
        s.issue_en   = 1'b0;
        s.issue_addr = '0;
        s.flush      = 1'b0;
        s.tag        = tag;
        return s;
    endfunction

    // Drive one cycle of stimulus, predict outputs, advance the model.
    task automatic apply(input stim_t s);
        exp_t            e;
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
        logic            b;
        @(negedge clk);
        #1;
        reset_n        = s.rst_n;
        for (int i = 0; i < NRD; i++) bus.rd_addr[i*AW +: AW] = s.ra[i];
        bus.wr0_en     = s.wr0_en;
        bus.wr0_addr   = s.wr0_addr;
        bus.wr0_data   = s.wr0_data;
        bus.wr1_en     = s.wr1_en;
        bus.wr1_addr   = s.wr1_addr;
        bus.wr1_data   = s.wr1_data;
        bus.issue_en   = s.issue_en;
        bus.issue_addr = s.issue_addr;
        bus.flush      = s.flush;

        // Reset is asynchronous: state is wiped as soon as it is asserted.
        if (!s.rst_n) begin
            for (int k = 0; k < NREGS; k++) begin
                m_regs[k] = '0;
                m_busy[k] = 1'b0;
            end
        end

        e.rd_data = '0;
        e.rd_busy = '0;
        e.tag     = s.tag;
        for (int i = 0; i < NRD; i++) begin
            a = s.ra[i];
            d = (a == 0) ? '0 : m_regs[a];
            b = (a == 0) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (s.rst_n && a != 0) begin
                if (s.wr1_en && s.wr1_addr == a) begin
                    d = s.wr1_data;
                    b = 1'b0;
                end else if (s.wr0_en && s.wr0_addr == a) begin
                    d = s.wr0_data;
                    b = 1'b0;
                end
            end
`endif
            e.rd_data[i*XLEN +: XLEN] = d;
            e.rd_busy[i]              = b;
        end
        for (int k = 0; k < NREGS; k++) e.busy_vec[k] = m_busy[k];
        exp_q.push_back(e);

        // Effect of the coming rising edge.
        if (s.rst_n) begin
            if (s.wr0_en && s.wr0_addr != 0) m_regs[s.wr0_addr] = s.wr0_data;
            if (s.wr1_en && s.wr1_addr != 0) m_regs[s.wr1_addr] = s.wr1_data;
            if (s.flush) begin
                for (int k = 0; k < NREGS; k++) m_busy[k] = 1'b0;
            end else begin
                if (s.wr0_en) m_busy[s.wr0_addr] = 1'b0;
                if (s.wr1_en) m_busy[s.wr1_addr] = 1'b0;
                if (s.issue_en && s.issue_addr != 0) m_busy[s.issue_addr] = 1'b1;
            end
            m_busy[0] = 1'b0;
        end
    endtask

    // Monitor: sample late in each cycle, compare with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vectors++;
                check({e.tag, ".rd_data"}, CW'(bus.rd_data), CW'(e.rd_data));
                check({e.tag, ".rd_busy"}, CW'(bus.rd_busy), CW'(e.rd_busy));
                check({e.tag, ".busy_vec"}, CW'(bus.busy_vec), CW'(e.busy_vec));
            end
        end
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        for (int k = 0; k < NREGS; k++) begin
            m_regs[k] = '0;
            m_busy[k] = 1'b0;
        end

        // Reset state, with writes and an issue that must be discarded.
        s = idle("reset0");
        s.rst_n = 1'b0;
        s.ra[0] = 5'd1; s.ra[1] = 5'd2;
        s.wr0_en = 1'b1; s.wr0_addr = 5'd1; s.wr0_data = 32'h1234_5678;
        s.issue_en = 1'b1; s.issue_addr = 5'd2;
        apply(s);
        s.tag = "reset1";
        apply(s);

        // Reset mid-operation, asserted between edges.
        s = idle("wr5");
        s.wr0_en = 1'b1; s.wr0_addr = 5'd5; s.wr0_data = 32'hDEAD_BEEF;
        apply(s);
        s = idle("iss7");
        s.ra[0] = 5'd5; s.ra[1] = 5'd7;
        s.issue_en = 1'b1; s.issue_addr = 5'd7;
        apply(s);
        s = idle("rd5_7");
        s.ra[0] = 5'd5; s.ra[1] = 5'd7;
        apply(s);
        s.tag = "async_rst";
        s.rst_n = 1'b0;
        apply(s);
        s = idle("post_rst");
        s.ra[0] = 5'd5; s.ra[1] = 5'd7;
        apply(s);

        // Zero register: writes and issue ignored.
        s = idle("zero_wr");
        s.wr0_en = 1'b1; s.wr0_addr = 5'd0; s.wr0_data = 32'hFFFF_FFFF;
        s.issue_en = 1'b1; s.issue_addr = 5'd0;
        apply(s);
        s = idle("zero_rd");
        apply(s);

        // Write conflict: load port wins, also for forwarding.
        s = idle("conflict");
        for (int i = 0; i < NRD; i++) s.ra[i] = 5'd3;
        s.wr0_en = 1'b1; s.wr0_addr = 5'd3; s.wr0_data = 32'h1111_1111;
        s.wr1_en = 1'b1; s.wr1_addr = 5'd3; s.wr1_data = 32'h2222_2222;
        apply(s);
        s = idle("conflict_rd");
        s.ra[0] = 5'd3;
        apply(s);

        // Scoreboard set/clear and issue-over-writeback priority.
        s = idle("iss9");
        s.ra[0] = 5'd9;
        s.issue_en = 1'b1; s.issue_addr = 5'd9;
        apply(s);
        s = idle("busy9");
        s.ra[0] = 5'd9;
        apply(s);
        s = idle("wb9");
        s.ra[0] = 5'd9;
        s.wr1_en = 1'b1; s.wr1_addr = 5'd9; s.wr1_data = 32'h0000_0055;
        apply(s);
        s = idle("clr9");
        s.ra[0] = 5'd9;
        apply(s);
        s = idle("iss_wb9");
        s.ra[0] = 5'd9;
        s.issue_en = 1'b1; s.issue_addr = 5'd9;
        s.wr0_en = 1'b1; s.wr0_addr = 5'd9; s.wr0_data = 32'h0000_0077;
        apply(s);
        s = idle("still9");
        s.ra[0] = 5'd9;
        apply(s);

        // Flush drops busy bits and a same-cycle issue.
        s = idle("iss4");
        s.issue_en = 1'b1; s.issue_addr = 5'd4;
        apply(s);
        s = idle("iss6");
        s.issue_en = 1'b1; s.issue_addr = 5'd6;
        apply(s);
        s = idle("flush_iss8");
        s.ra[0] = 5'd4; s.ra[1] = 5'd6; s.ra[2] = 5'd8;
        s.flush = 1'b1;
        s.issue_en = 1'b1; s.issue_addr = 5'd8;
        apply(s);
        s = idle("post_flush");
        s.ra[0] = 5'd4; s.ra[1] = 5'd6; s.ra[2] = 5'd8;
        apply(s);

        // Same-cycle read of a register being written, all ports.
        s = idle("byp_rst");
        s.rst_n = 1'b0;
        apply(s);
        s = idle("byp12");
        for (int i = 0; i < NRD; i++) s.ra[i] = 5'd12;
        s.wr0_en = 1'b1; s.wr0_addr = 5'd12; s.wr0_data = 32'hA5A5_A5A5;
        apply(s);
        s = idle("after12");
        for (int i = 0; i < NRD; i++) s.ra[i] = 5'd12;
        apply(s);

        // Randomised traffic, addresses biased toward a small window.
        for (int n = 0; n < 400; n++) begin
            s = idle("rand");
            s.rst_n = ($urandom_range(0, 99) != 0);
            for (int i = 0; i < NRD; i++)
                s.ra[i] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7)
                                                   : $urandom_range(0, NREGS-1));
            s.wr0_en     = 1'($urandom_range(0, 1));
            s.wr0_addr   = AW'($urandom_range(0, 7));
            s.wr0_data   = $urandom();
            s.wr1_en     = 1'($urandom_range(0, 2) == 0);
            s.wr1_addr   = AW'($urandom_range(0, 7));
            s.wr1_data   = $urandom();
            s.issue_en   = 1'($urandom_range(0, 1));
            s.issue_addr = AW'($urandom_range(0, 7));
            s.flush      = 1'($urandom_range(0, 19) == 0);
            apply(s);
        end

        // Let the monitor consume the last prediction.
        @(negedge clk);
        #6;
        stim_done = 1'b1;
        check("drain", CW'(exp_q.size()), CW'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule
